// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO.
package sync_fifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 16;

  // Smallest n such that 2**n >= v.
  function automatic int unsigned log2_ceil(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
module fifo_mem_2p #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port, combinational.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count-register flags and overflow/underflow pulses.
// Build option: SYNC_FIFO_FWFT_EN selects first-word-fall-through reads
// (head word visible combinationally); otherwise reads have one-cycle latency.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned ADDR_W   = log2_ceil(DEPTH),
  localparam int unsigned CNT_W    = ADDR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rvalid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic [WIDTH-1:0] mem_rdata;
  logic             wr_acc_c;
  logic             rd_acc_c;

  // Accept decisions use the registered (pre-edge) flags only.
  assign wr_acc_c = wr_en_i & ~full_o;
  assign rd_acc_c = rd_en_i & ~empty_o;

  fifo_mem_2p #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .wr_en_i (wr_acc_c),
    .waddr_i (wr_ptr[ADDR_W-1:0]),
    .wdata_i (wdata_i),
    .raddr_i (rd_ptr[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

  // Next occupancy: simultaneous accepted read and write cancel out.
  always_comb begin
    count_next = count_o;
    case ({wr_acc_c, rd_acc_c})
      2'b10:   count_next = count_o + CNT_W'(1);
      2'b01:   count_next = count_o - CNT_W'(1);
      default: count_next = count_o;
    endcase
  end

  // Pointers, occupancy, flags (decoded from next count) and error pulses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_o        <= '0;
      full_o         <= 1'b0;
      empty_o        <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + CNT_W'(1);
      if (rd_acc_c) rd_ptr <= rd_ptr + CNT_W'(1);
      count_o        <= count_next;
      full_o         <= (count_next == CNT_W'(DEPTH));
      empty_o        <= (count_next == '0);
      almost_full_o  <= (count_next >= CNT_W'(AF_THRESH));
      almost_empty_o <= (count_next <= CNT_W'(AE_THRESH));
      overflow_o     <= wr_en_i & full_o;
      underflow_o    <= rd_en_i & empty_o;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; valid whenever the FIFO is non-empty.
  assign rdata_o  = mem_rdata;
  assign rvalid_o = ~empty_o;
`else
  // Registered read: data appears the cycle after an accepted read, else held.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
    end else begin
      rvalid_o <= rd_acc_c;
      if (rd_acc_c) rdata_o <= mem_rdata;
    end
  end
`endif

  // Occupancy register must always agree with the pointer difference.
  count_matches_ptrs: assert property (@(posedge clk_i) disable iff (!rst_i)
    count_o == CNT_W'(wr_ptr - rd_ptr));

endmodule
